afe_scan_sequencer: RTL and testbench
=====================================

# afe_scan_sequencer

Synchronous injection-scan controller for the AFE readout CPLD. It generates a programmable train of charge-injection pulses on `INJ_OUT`, samples the discriminator output `COMP` during each injection cycle, and accumulates hit count and time-over-threshold (TOT) statistics. Host logic starts a scan with a one-cycle `START` pulse and reads the results after `DONE`. Results stay stable in `IDLE` until the next scan.

## Interface
Parameters:
- `CNT_W`, 8: width of the per-injection TOT counter (saturating).
- `NINJ_W`, 8: width of the injection count and the hit counter.

Ports:
- `CLK` in 1: system clock. One clock domain; every register uses the rising edge.
- `RST` in 1: reset, synchronous, active-high.
- `START` in 1: scan request. Only sampled in `IDLE`.
- `CFG_NINJ` in `NINJ_W`: number of injections. Latched on `START`.
- `CFG_HIGH` in 8: cycles `INJ_OUT` is high per injection. A value of 0 acts as 1.
- `CFG_LOW` in 8: cycles `INJ_OUT` is low per injection, which is the tail of the measurement window. A value of 0 acts as 1.
- `COMP` in 1: discriminator output. Asynchronous to `CLK`.
- `INJ_OUT` out 1: injection pulse, driven directly from a register.
- `BUSY` out 1: scan in progress.
- `DONE` out 1: one-cycle pulse that marks scan completion.
- `HIT_CNT` out `NINJ_W`: number of injections with at least one synchronized `COMP` high cycle.
- `TOT_SUM` out `CNT_W+NINJ_W`: sum of the per-injection TOT values. It cannot overflow.
- `TOT_MAX` out `CNT_W`: largest per-injection TOT value.
- `OVF` out 1: set when any per-injection TOT counter saturated.

## Operation
Input handling:
- `COMP` passes through a two-flop synchronizer to give `comp_s`. All measurement logic uses `comp_s`.
- The configuration inputs are latched on `START` acceptance. Changes during a scan have no effect.

States:
- `IDLE`:
  - If `START`=1 and the latched `CFG_NINJ`≠0: clear all result outputs, the phase counter, the injection counter, the TOT counter and the hit flag, then go to `HIGH`.
  - If `START`=1 and `CFG_NINJ`=0: clear the results, pulse `DONE`, and stay in `IDLE`.
- `HIGH`:
  - `INJ_OUT`=1.
  - Lasts max(`CFG_HIGH`,1) cycles, then go to `LOW`.
- `LOW`:
  - `INJ_OUT`=0.
  - Lasts max(`CFG_LOW`,1) cycles.
  - On the last cycle, commit the per-injection results (see below).
  - Then go to `HIGH` if injections remain. Otherwise go to `IDLE` and pulse `DONE`.

Per-injection measurement window (every `HIGH` and `LOW` cycle):
- The TOT counter increments when `comp_s`=1 and saturates at 2^`CNT_W`−1.
- The hit flag sets when `comp_s`=1.
- `OVF` sets when the increment is attempted while the counter is already at maximum.

Commit on the last `LOW` cycle:
- `HIT_CNT` += hit flag.
- `TOT_SUM` += TOT value, including that cycle's increment.
- `TOT_MAX` = max(`TOT_MAX`, TOT value).
- Clear the TOT counter and the hit flag for the next injection.

Other rules:
- `BUSY`=1 in `HIGH` and `LOW`, and 0 in `IDLE`.
- `START` while `BUSY` is ignored and not queued.
- Reset values: `INJ_OUT`=0, `BUSY`=0, `DONE`=0, `HIT_CNT`=0, `TOT_SUM`=0, `TOT_MAX`=0, `OVF`=0. State is `IDLE` and the synchronizer flops are 0.
- `RST` during a scan aborts immediately. The next cycle shows the reset values, and no `DONE` is issued.
- Simultaneous `RST` and `START`: `RST` wins.

## Timing
- `START` sampled at edge k: `INJ_OUT` and `BUSY` are high from edge k to edge k+H.
  - H = max(`CFG_HIGH`,1), L = max(`CFG_LOW`,1).
- Injection period is exactly H+L cycles. `INJ_OUT` has no gap cycles between injections.
- A scan of N injections is busy for N·(H+L) cycles.
- `DONE` is high in the cycle after the last `LOW` cycle, and `BUSY` is already 0 in that cycle.
- Results are valid when `DONE`=1 and stay held until the next accepted `START`.
- A new `START` is accepted during the `DONE` cycle.
- `COMP`-to-count latency is 2 cycles because of the synchronizer. Activity in the last 2 window cycles counts toward the next injection, or is lost on the final injection.
- `CFG_NINJ`=0 case: `DONE` is high the cycle after the `START` edge and `BUSY` never asserts.

## Test plan
- **No signal:** `CFG_NINJ`=4, `CFG_HIGH`=2, `CFG_LOW`=10, `COMP`=0 → 4 `INJ_OUT` pulses, each 2 cycles high with a 12-cycle period. `BUSY` for 48 cycles, `DONE` 1 cycle later, `HIT_CNT`=0, `TOT_SUM`=0, `TOT_MAX`=0, `OVF`=0.
- **Fixed pulse:** same configuration, `COMP` high for 5 cycles starting 1 cycle after each `INJ_OUT` rise → `HIT_CNT`=4, `TOT_SUM`=20, `TOT_MAX`=5, `OVF`=0.
- **Saturation:** `CNT_W`=4, `CFG_NINJ`=1, `CFG_HIGH`=10, `CFG_LOW`=20, `COMP` held at 1 → `TOT_MAX`=15, `TOT_SUM`=15, `HIT_CNT`=1, `OVF`=1.
- **Zero injections and clamping:** `CFG_NINJ`=0 → `DONE` 1 cycle after `START`, `BUSY`=0 throughout. `CFG_HIGH`=0 with `CFG_LOW`=0 → 1-cycle high, 1-cycle low pulses.
- **Mid-scan `START` and `RST`:** `START` during `BUSY` → ignored, and the results match a single scan. `RST` during injection 2 of 4 → next cycle `INJ_OUT`=0, `BUSY`=0, all results 0, and no `DONE`.
- **Back-to-back scans:** `START` in the `DONE` cycle → the second scan starts with cleared results. Changing the configuration mid-scan does not affect the running scan.

Source files
------------

// File: rtl/afe_scan_sequencer.sv
// Injection-scan controller: drives a programmable INJ_OUT pulse train and
// accumulates hit count and time-over-threshold statistics from a synchronized COMP.
module afe_scan_sequencer #(
    parameter int CNT_W  = 8,
    parameter int NINJ_W = 8
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    START,
    input  logic [NINJ_W-1:0]       CFG_NINJ,
    input  logic [7:0]              CFG_HIGH,
    input  logic [7:0]              CFG_LOW,
    input  logic                    COMP,
    output logic                    INJ_OUT,
    output logic                    BUSY,
    output logic                    DONE,
    output logic [NINJ_W-1:0]       HIT_CNT,
    output logic [CNT_W+NINJ_W-1:0] TOT_SUM,
    output logic [CNT_W-1:0]        TOT_MAX,
    output logic                    OVF
);

    localparam int SUM_W = CNT_W + NINJ_W;

    typedef enum logic [1:0] {
        S_IDLE,
        S_HIGH,
        S_LOW
    } state_t;

    state_t              state_q, state_d;
    logic                comp_meta_q, comp_s_q;
    logic [NINJ_W-1:0]   ninj_q, ninj_d;
    logic [7:0]          high_last_q, high_last_d;
    logic [7:0]          low_last_q, low_last_d;
    logic [7:0]          phase_q, phase_d;
    logic [NINJ_W-1:0]   inj_q, inj_d;
    logic [CNT_W-1:0]    tot_q, tot_d;
    logic                hit_q, hit_d;
    logic                inj_out_q, inj_out_d;
    logic                done_q, done_d;
    logic [NINJ_W-1:0]   hit_cnt_q, hit_cnt_d;
    logic [SUM_W-1:0]    tot_sum_q, tot_sum_d;
    logic [CNT_W-1:0]    tot_max_q, tot_max_d;
    logic                ovf_q, ovf_d;

    logic                tot_full;
    logic [CNT_W-1:0]    tot_next;
    logic                hit_next;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= S_IDLE;
            comp_meta_q <= 1'b0;
            comp_s_q    <= 1'b0;
            ninj_q      <= '0;
            high_last_q <= '0;
            low_last_q  <= '0;
            phase_q     <= '0;
            inj_q       <= '0;
            tot_q       <= '0;
            hit_q       <= 1'b0;
            inj_out_q   <= 1'b0;
            done_q      <= 1'b0;
            hit_cnt_q   <= '0;
            tot_sum_q   <= '0;
            tot_max_q   <= '0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            comp_meta_q <= COMP;
            comp_s_q    <= comp_meta_q;
            ninj_q      <= ninj_d;
            high_last_q <= high_last_d;
            low_last_q  <= low_last_d;
            phase_q     <= phase_d;
            inj_q       <= inj_d;
            tot_q       <= tot_d;
            hit_q       <= hit_d;
            inj_out_q   <= inj_out_d;
            done_q      <= done_d;
            hit_cnt_q   <= hit_cnt_d;
            tot_sum_q   <= tot_sum_d;
            tot_max_q   <= tot_max_d;
            ovf_q       <= ovf_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        ninj_d      = ninj_q;
        high_last_d = high_last_q;
        low_last_d  = low_last_q;
        phase_d     = phase_q;
        inj_d       = inj_q;
        tot_d       = tot_q;
        hit_d       = hit_q;
        done_d      = 1'b0;
        hit_cnt_d   = hit_cnt_q;
        tot_sum_d   = tot_sum_q;
        tot_max_d   = tot_max_q;
        ovf_d       = ovf_q;

        tot_full = &tot_q;
        tot_next = tot_q + CNT_W'(comp_s_q & ~tot_full);
        hit_next = hit_q | comp_s_q;

        unique case (state_q)
            S_IDLE: begin
                if (START) begin
                    // Durations are stored as the last phase index, so 0 and 1 both mean one cycle.
                    ninj_d      = CFG_NINJ;
                    high_last_d = (CFG_HIGH == 8'd0) ? 8'd0 : CFG_HIGH - 8'd1;
                    low_last_d  = (CFG_LOW == 8'd0) ? 8'd0 : CFG_LOW - 8'd1;
                    hit_cnt_d   = '0;
                    tot_sum_d   = '0;
                    tot_max_d   = '0;
                    ovf_d       = 1'b0;
                    if (CFG_NINJ != '0) begin
                        phase_d = '0;
                        inj_d   = '0;
                        tot_d   = '0;
                        hit_d   = 1'b0;
                        state_d = S_HIGH;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            S_HIGH, S_LOW: begin
                tot_d = tot_next;
                hit_d = hit_next;
                if (comp_s_q && tot_full) begin
                    ovf_d = 1'b1;
                end
                if (state_q == S_HIGH) begin
                    if (phase_q == high_last_q) begin
                        phase_d = '0;
                        state_d = S_LOW;
                    end else begin
                        phase_d = phase_q + 8'd1;
                    end
                end else if (phase_q == low_last_q) begin
                    hit_cnt_d = hit_cnt_q + NINJ_W'(hit_next);
                    tot_sum_d = tot_sum_q + SUM_W'(tot_next);
                    tot_max_d = (tot_next > tot_max_q) ? tot_next : tot_max_q;
                    tot_d     = '0;
                    hit_d     = 1'b0;
                    phase_d   = '0;
                    inj_d     = inj_q + NINJ_W'(1);
                    if (inj_q == ninj_q - NINJ_W'(1)) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_HIGH;
                    end
                end else begin
                    phase_d = phase_q + 8'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        inj_out_d = (state_d == S_HIGH);
    end

    assign INJ_OUT = inj_out_q;
    assign BUSY    = (state_q != S_IDLE);
    assign DONE    = done_q;
    assign HIT_CNT = hit_cnt_q;
    assign TOT_SUM = tot_sum_q;
    assign TOT_MAX = tot_max_q;
    assign OVF     = ovf_q;

endmodule

// File: tb/tb_afe_scan_sequencer.sv
// Bench for afe_scan_sequencer: directed and random scans checked against a
// per-window counting model built from the recorded COMP history.
module tb_afe_scan_sequencer;

    localparam int CW = 4;
    localparam int NW = 8;
    localparam int SW = CW + NW;
    localparam int TMAX = (1 << CW) - 1;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          START = 1'b0;
    logic [NW-1:0] CFG_NINJ = '0;
    logic [7:0]    CFG_HIGH = '0;
    logic [7:0]    CFG_LOW = '0;
    logic          COMP = 1'b0;
    logic          INJ_OUT, BUSY, DONE, OVF;
    logic [NW-1:0] HIT_CNT;
    logic [SW-1:0] TOT_SUM;
    logic [CW-1:0] TOT_MAX;

    int n_assert = 0;
    int n_fail = 0;

    afe_scan_sequencer #(.CNT_W(CW), .NINJ_W(NW)) dut (
        .CLK(CLK), .RST(RST), .START(START), .CFG_NINJ(CFG_NINJ),
        .CFG_HIGH(CFG_HIGH), .CFG_LOW(CFG_LOW), .COMP(COMP),
        .INJ_OUT(INJ_OUT), .BUSY(BUSY), .DONE(DONE), .HIT_CNT(HIT_CNT),
        .TOT_SUM(TOT_SUM), .TOT_MAX(TOT_MAX), .OVF(OVF)
    );

    always #5 CLK = ~CLK;

    // COMP value seen at each rising edge, indexed by edge number
    bit          hist [0:65535];
    logic [15:0] ecnt = '0;
    always @(posedge CLK) begin
        hist[ecnt] = COMP;
        ecnt = ecnt + 16'd1;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // COMP level to be sampled at edge k+c of a scan starting at edge k
    function automatic logic comp_for(input int mode, input int c, input int p, input int total);
        case (mode)
            1: return (c < total) && ((c % p) >= 2) && ((c % p) <= 6);
            2: return 1'b1;
            3: return 1'($urandom_range(0, 1));
            default: return 1'b0;
        endcase
    endfunction

    task automatic run_scan(input string name, input int ninj, input int h, input int l,
                            input int mode, input int mid_c, input int rst_c);
        int H, L, P, total, k, wave_err, cnt, e_hit, e_sum, e_max, e_ovf;
        logic e_inj, e_busy, e_done;
        logic [15:0] idx;
        H = (h == 0) ? 1 : h;
        L = (l == 0) ? 1 : l;
        P = H + L;
        total = ninj * P;
        CFG_NINJ = NW'(ninj);
        CFG_HIGH = 8'(h);
        CFG_LOW  = 8'(l);
        START = 1'b1;
        k = int'(ecnt);
        COMP = comp_for(mode, 0, P, total);
        tick();
        START = 1'b0;
        wave_err = 0;
        for (int c = 0; c <= total; c++) begin
            e_busy = (c < total);
            e_inj  = e_busy && ((c % P) < H);
            e_done = (c == total);
            if ({INJ_OUT, BUSY, DONE} !== {e_inj, e_busy, e_done}) wave_err++;
            if (c == 0) begin
                check({name, ":clear"}, {HIT_CNT, TOT_SUM, TOT_MAX, OVF}, 32'd0);
            end
            if (c == rst_c) begin
                RST = 1'b1;
                COMP = 1'b0;
                tick();
                RST = 1'b0;
                check({name, ":rst_ctl"}, {INJ_OUT, BUSY, DONE}, 32'd0);
                check({name, ":rst_res"}, {HIT_CNT, TOT_SUM, TOT_MAX, OVF}, 32'd0);
                check({name, ":wave_pre_rst"}, wave_err, 0);
                wave_err = 0;
                for (int w = 0; w < total; w++) begin
                    tick();
                    if ({INJ_OUT, BUSY, DONE} !== 3'b000) wave_err++;
                end
                check({name, ":quiet_after_rst"}, wave_err, 0);
                return;
            end
            if (c == total) break;
            if (c == mid_c) begin
                START = 1'b1;
                CFG_NINJ = NW'($urandom_range(1, 9));
                CFG_HIGH = 8'($urandom);
                CFG_LOW  = 8'($urandom);
            end else begin
                START = 1'b0;
            end
            COMP = comp_for(mode, c + 1, P, total);
            tick();
        end
        START = 1'b0;
        COMP = 1'b0;
        check({name, ":wave"}, wave_err, 0);
        e_hit = 0; e_sum = 0; e_max = 0; e_ovf = 0;
        for (int i = 0; i < ninj; i++) begin
            cnt = 0;
            for (int j = 0; j < P; j++) begin
                idx = 16'(k + i * P + j - 1);
                cnt += int'(hist[idx]);
            end
            if (cnt > TMAX) begin
                e_ovf = 1;
                cnt = TMAX;
            end
            if (cnt > 0) e_hit++;
            e_sum += cnt;
            if (cnt > e_max) e_max = cnt;
        end
        check({name, ":hit_cnt"}, HIT_CNT, e_hit);
        check({name, ":tot_sum"}, TOT_SUM, e_sum);
        check({name, ":tot_max"}, TOT_MAX, e_max);
        check({name, ":ovf"}, OVF, e_ovf);
    endtask

    initial begin
        // reset asserted together with a START request
        #1;
        RST = 1'b1;
        START = 1'b1;
        CFG_NINJ = 8'd3;
        CFG_HIGH = 8'd2;
        CFG_LOW = 8'd2;
        tick();
        tick();
        check("reset_ctl", {INJ_OUT, BUSY, DONE}, 32'd0);
        check("reset_res", {HIT_CNT, TOT_SUM, TOT_MAX, OVF}, 32'd0);
        RST = 1'b0;
        START = 1'b0;
        repeat (3) tick();
        check("idle_ctl", {INJ_OUT, BUSY, DONE}, 32'd0);

        run_scan("no_signal", 4, 2, 10, 0, -1, -1);
        repeat (3) tick();
        run_scan("fixed_pulse", 4, 2, 10, 1, -1, -1);
        repeat (2) tick();
        run_scan("saturation", 1, 10, 20, 2, -1, -1);
        repeat (4) tick();
        run_scan("zero_ninj", 0, 5, 5, 2, -1, -1);
        repeat (2) tick();
        check("zero_ninj_idle", {INJ_OUT, BUSY, DONE}, 32'd0);
        run_scan("clamp", 3, 0, 0, 3, -1, -1);
        repeat (2) tick();
        run_scan("mid_start", 4, 3, 6, 3, 10, -1);
        repeat (2) tick();
        run_scan("mid_reset", 4, 3, 6, 2, -1, 12);
        repeat (3) tick();
        run_scan("b2b_first", 2, 3, 4, 2, 5, -1);
        run_scan("b2b_second", 2, 3, 4, 0, -1, -1);
        run_scan("b2b_third", 3, 1, 2, 1, -1, -1);
        repeat (2) tick();

        for (int r = 0; r < 8; r++) begin
            run_scan("random", $urandom_range(1, 5), $urandom_range(0, 6),
                     $urandom_range(0, 12), 3, (r % 2 == 0) ? 4 : -1, -1);
            if (r % 3 == 0) repeat (2) tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
